// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS pipeline: loads memory from a host stream, seeds the
// register file, pulses CPU reset, runs to HALT or timeout, then dumps a memory window.
module mips_run_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int NREGS     = 32,
    parameter int REG_AW    = 5,
    parameter int INIT_REGS = 1,
    parameter int TIMEOUT   = 1000,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              cpu_rst,
    output logic              cpu_run,
    input  logic              cpu_halted,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REGINIT, S_CPURST, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
    } state_t;

    localparam logic [REG_AW-1:0] LAST_REG  = REG_AW'(NREGS - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [REG_AW-1:0] reg_k;
    logic              rst_cnt;
    logic              fresh_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              to_q;

    logic              start_ok;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] win_addr;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign idx_inc  = idx_q + IDX_ONE;
    // Address arithmetic stays in ADDR_W bits so the dump window wraps around memory.
    assign win_addr = base_q + idx_q[ADDR_W-1:0];

    assign timed_out   = to_q;
    assign cycle_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (load_valid && load_last)
                    state_nxt = (INIT_REGS != 0) ? S_REGINIT : S_CPURST;
            end
            S_REGINIT: if (reg_k == LAST_REG) state_nxt = S_CPURST;
            S_CPURST:  if (rst_cnt) state_nxt = S_RUN;
            S_RUN: begin
                // Halt wins over a coinciding timeout.
                if (cpu_halted)               state_nxt = S_DUMP_RD;
                else if (cnt_inc == TIMEOUT_C) state_nxt = S_DUMP_RD;
            end
            S_DUMP_RD: state_nxt = (len_q == '0) ? S_DONE : S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (dump_ready) state_nxt = (idx_inc == len_q) ? S_DONE : S_DUMP_RD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_k   <= '0;
            rst_cnt <= 1'b0;
            idx_q   <= '0;
            fresh_q <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            reg_k   <= (state == S_REGINIT) ? reg_k + REG_AW'(1) : '0;
            rst_cnt <= (state == S_CPURST) && !rst_cnt;
            fresh_q <= (state == S_DUMP_RD) && (state_nxt == S_DUMP_OUT);
            if (start_ok) begin
                idx_q <= '0;
                cnt_q <= '0;
                to_q  <= 1'b0;
            end
            if (state == S_RUN && !cpu_halted) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == TIMEOUT_C) to_q <= 1'b1;
            end
            if (state == S_DUMP_OUT && dump_ready) idx_q <= idx_inc;
        end
    end

    // Read data arrives in the first DUMP_OUT cycle and is held here for any stall.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            base_q <= dump_base;
            len_q  <= dump_len;
        end
        if (fresh_q) data_q <= mem_rdata;
    end

    always_comb begin
        load_ready = 1'b0;
        mem_sel    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        reg_we     = 1'b0;
        reg_addr   = '0;
        reg_wdata  = '0;
        cpu_rst    = 1'b0;
        cpu_run    = 1'b0;
        dump_valid = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: cpu_rst = 1'b1;
            S_LOAD: begin
                busy       = 1'b1;
                mem_sel    = 1'b1;
                load_ready = 1'b1;
                mem_we     = load_valid;
                mem_addr   = load_addr;
                mem_wdata  = load_data;
            end
            S_REGINIT: begin
                busy      = 1'b1;
                reg_we    = 1'b1;
                reg_addr  = reg_k;
                reg_wdata = DATA_W'(reg_k);
            end
            S_CPURST: begin
                busy    = 1'b1;
                cpu_rst = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                cpu_run = 1'b1;
            end
            S_DUMP_RD: begin
                busy     = 1'b1;
                mem_sel  = 1'b1;
                mem_addr = win_addr;
            end
            S_DUMP_OUT: begin
                busy       = 1'b1;
                mem_sel    = 1'b1;
                mem_addr   = win_addr;
                dump_valid = 1'b1;
                dump_addr  = win_addr;
                dump_data  = fresh_q ? mem_rdata : data_q;
            end
            S_DONE: done = 1'b1;
            default: cpu_rst = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl with a behavioural memory and a stub CPU
// that writes Mem[121]=Mem[120]+45 and halts after a programmable number of cycles.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        mem_sel, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        cpu_rst, cpu_run, cpu_halted;
    logic [9:0]  dump_base = '0;
    logic [10:0] dump_len = '0;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [9:0]  dump_addr;
    logic [31:0] dump_data;
    logic        busy, done, timed_out;
    logic [15:0] cycle_count;

    mips_run_ctrl #(.TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int halt_at = 0;
    int run_cnt = 0;

    assign cpu_halted = (halt_at != 0) && (run_cnt >= halt_at);

    always @(posedge clk) begin
        if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
        else if (!mem_sel && cpu_run && !cpu_halted && run_cnt == 2) mem[121] <= mem[120] + 32'd45;
        mem_rdata <= mem[mem_addr];
        if (cpu_rst) run_cnt <= 0;
        else if (cpu_run && !cpu_halted) run_cnt <= run_cnt + 1;
    end

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] regs [0:31];
    int  we_run = 0, we_max = 0;
    int  rst_len = 0, last_rst = 0;
    logic rst_prev = 1'b0, run_prev = 1'b0, rise_ok = 1'b0, seen_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n && dump_valid && dump_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL dump_extra: got addr %0d data %0d, required no word", dump_addr, dump_data);
            end else begin
                mon_e = sb.pop_front();
                if (dump_addr !== mon_e.a || dump_data !== mon_e.d) begin
                    n_bad++;
                    $display("FAIL dump_word: got addr %0d data %0d, required addr %0d data %0d",
                             dump_addr, dump_data, mon_e.a, mon_e.d);
                end
            end
        end
        if (dump_valid) seen_valid = 1'b1;
        if (reg_we) begin
            regs[reg_addr] = reg_wdata;
            we_run++;
            if (we_run > we_max) we_max = we_run;
        end else we_run = 0;
        if (cpu_rst) rst_len++;
        else begin
            if (rst_prev) last_rst = rst_len;
            rst_len = 0;
        end
        if (cpu_run && !run_prev) rise_ok = rst_prev;
        rst_prev = cpu_rst;
        run_prev = cpu_run;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic prep();
        for (int k = 0; k < 32; k++) regs[k] = 32'hFFFF_FFFF;
        we_max = 0;
        seen_valid = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        @(posedge clk); #1;
        dump_base = b;
        dump_len  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d, input logic last);
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        load_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_ready) break;
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done", done, 1);
    endtask

    task automatic wait_sig_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dump_valid) break;
        end
        chk("dump_valid_seen", dump_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_cycle_count", cycle_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Session 1: program load, register init, halt after 20 cycles, 2-word dump
        prep();
        halt_at = 20;
        do_start(10'd120, 11'd2);
        for (int i = 0; i < 8; i++) load_word(10'(i), 32'h1000 + 32'(i), 1'b0);
        load_word(10'd120, 32'd85, 1'b1);
        push(10'd120, 32'd85);
        push(10'd121, 32'd130);
        wait_done(300);
        chk("s1_cycle_count", cycle_count, 20);
        chk("s1_timed_out", timed_out, 0);
        chk("s1_busy", busy, 0);
        chk("s1_cpu_run", cpu_run, 0);
        chk("s1_cpu_rst", cpu_rst, 0);
        chk("s1_reginit_run", we_max, 32);
        bad = 0;
        for (int k = 0; k < 32; k++) if (regs[k] !== 32'(k)) bad++;
        chk("s1_regfile_bad", bad, 0);
        chk("s1_cpu_rst_len", last_rst, 2);
        chk("s1_run_after_rst", rise_ok, 1);
        chk("s1_sb_empty", sb.size(), 0);

        // Session 2: CPU never halts, timeout, overwrite of a loaded address
        prep();
        halt_at = 0;
        do_start(10'd4, 11'd3);
        load_word(10'd5, 32'hAA, 1'b0);
        load_word(10'd5, 32'hBB, 1'b1);
        push(10'd4, 32'h1004);
        push(10'd5, 32'hBB);
        push(10'd6, 32'h1006);
        wait_done(400);
        chk("s2_timed_out", timed_out, 1);
        chk("s2_cycle_count", cycle_count, 50);
        chk("s2_sb_empty", sb.size(), 0);

        // Session 3: wrapping window with a stalled consumer on the first word
        prep();
        halt_at = 3;
        dump_ready = 1'b0;
        do_start(10'd1022, 11'd4);
        load_word(10'd1022, 32'h11, 1'b0);
        load_word(10'd1023, 32'h22, 1'b0);
        load_word(10'd0, 32'h33, 1'b0);
        load_word(10'd1, 32'h44, 1'b1);
        push(10'd1022, 32'h11);
        push(10'd1023, 32'h22);
        push(10'd0, 32'h33);
        push(10'd1, 32'h44);
        wait_sig_valid(200);
        for (int i = 0; i < 5; i++) begin
            chk("s3_stall_valid", dump_valid, 1);
            chk("s3_stall_addr", dump_addr, 1022);
            chk("s3_stall_data", dump_data, 32'h11);
            @(negedge clk);
        end
        @(posedge clk); #1 dump_ready = 1'b1;
        wait_done(200);
        chk("s3_cycle_count", cycle_count, 3);
        chk("s3_timed_out", timed_out, 0);
        chk("s3_sb_empty", sb.size(), 0);

        // Session 4: empty dump window, start pulsed while running
        prep();
        halt_at = 4;
        do_start(10'd0, 11'd0);
        load_word(10'd200, 32'd7, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_run) break;
        end
        chk("s4_running", cpu_run, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200);
        chk("s4_no_dump_valid", seen_valid, 0);
        chk("s4_cycle_count", cycle_count, 4);

        // Session 5: reset during DUMP_OUT, then a full session afterwards
        prep();
        halt_at = 20;
        dump_ready = 1'b0;
        do_start(10'd120, 11'd2);
        load_word(10'd120, 32'd85, 1'b1);
        push(10'd120, 32'd85);
        push(10'd121, 32'd130);
        wait_sig_valid(300);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dump_valid", dump_valid, 0);
        chk("abort_cpu_rst", cpu_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_mem_sel", mem_sel, 0);
        chk("abort_cycle_count", cycle_count, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dump_ready = 1'b1;
        chk("abort_idle_done", done, 0);

        prep();
        do_start(10'd120, 11'd2);
        load_word(10'd120, 32'd85, 1'b1);
        push(10'd120, 32'd85);
        push(10'd121, 32'd130);
        wait_done(300);
        chk("s6_cycle_count", cycle_count, 20);
        chk("s6_timed_out", timed_out, 0);
        chk("s6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesisable single-clock run controller for the MIPS pipeline.
- Loads program and data words into the shared instruction/data memory from a host stream, then initialises the register file (Reg[k]=k when enabled).
- Pulses CPU reset (PC=0, HALTED=0, TAKEN_BRANCH=0) and runs the CPU until HALT or timeout.
- Streams a programmable memory window out on a ready/valid dump port; counts run cycles.

Parameters:
- DATA_W, 32, memory/register data width.
- ADDR_W, 10, memory word-address width (depth 2^ADDR_W).
- NREGS, 32, register-file entries initialised in REGINIT.
- REG_AW, 5, register address width (2^REG_AW >= NREGS).
- INIT_REGS, 1, 1 = run REGINIT state; 0 = skip it.
- TIMEOUT, 1000, maximum RUN cycles before forced stop.
- CNT_W, 16, cycle_count width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a session; sampled only in IDLE/DONE.
- load_valid  in  1  host load word valid.
- load_ready  out  1  controller accepts load word.
- load_addr  in  ADDR_W  target memory word address.
- load_data  in  DATA_W  word to write.
- load_last  in  1  final word of load burst.
- mem_sel  out  1  1 = controller owns the memory port; 0 = CPU owns it.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address.
- reg_we  out  1  register-file write strobe.
- reg_addr  out  REG_AW  register index.
- reg_wdata  out  DATA_W  register write data.
- cpu_rst  out  1  holds CPU in reset (PC=0, HALTED=0, TAKEN_BRANCH=0).
- cpu_run  out  1  CPU clock enable.
- cpu_halted  in  1  CPU HALTED flag.
- dump_base  in  ADDR_W  first dump address, latched at start.
- dump_len  in  ADDR_W+1  number of dump words, latched at start.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer ready.
- dump_addr  out  ADDR_W  address of the current dump word.
- dump_data  out  DATA_W  dumped word.
- busy  out  1  session active.
- done  out  1  session complete; held until the next start.
- timed_out  out  1  the run ended by timeout.
- cycle_count  out  CNT_W  RUN cycles, saturating.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except cpu_rst=1. Reset mid-session aborts immediately; no partial dump continues after release.
- States: IDLE -> LOAD -> REGINIT -> CPURST -> RUN -> DUMP_RD -> DUMP_OUT -> DONE.
- start in IDLE or DONE: latch dump_base and dump_len; clear done, timed_out and cycle_count; enter LOAD. start is ignored while busy=1.
- LOAD: mem_sel=1 and load_ready=1.
  - On valid&ready: mem_we=1 with the same-cycle addr/data (combinational pass-through, zero latency).
  - A word with load_last=1 -> REGINIT if INIT_REGS, else CPURST.
  - A later write to the same address overwrites the earlier one.
- REGINIT: one write per cycle, reg_addr=k, reg_wdata=k, for k=0..NREGS-1 (NREGS cycles), then CPURST.
- CPURST: cpu_rst=1 for exactly 2 cycles, then RUN.
- RUN: mem_sel=0, cpu_run=1, cpu_rst=0.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - cpu_halted=1 sampled -> DUMP_RD; cpu_run drops on the next cycle.
  - If cycle_count reaches TIMEOUT with no halt: timed_out=1, then DUMP_RD.
  - Halt and timeout in the same cycle: treated as halt, timed_out=0.
- DUMP_RD: mem_sel=1 and mem_addr=dump_base+i (modulo 2^ADDR_W, so the window wraps); go to DUMP_OUT next cycle.
  - dump_len=0 goes straight to DONE with no dump_valid.
- DUMP_OUT: dump_valid=1 with dump_data = captured mem_rdata and dump_addr held stable until dump_ready.
  - On handshake: i++; if i==dump_len -> DONE, else DUMP_RD.
  - Throughput is one word per 2 cycles maximum.
- DONE: done=1, busy=0, cpu_run=0, cpu_rst=0; the CPU state is left for inspection.
- busy=1 in every state except IDLE and DONE.

Test Plan:
- Load 8 program words at 0..7 plus Mem[120]=85 (load_last on the final word); stub CPU halts after 20 RUN cycles; dump_base=120, dump_len=2. Required: Mem[120]=85, then Mem[121]=130 (85+45), cycle_count=20, timed_out=0, done=1.
- INIT_REGS=1: REGINIT writes Reg[k]=k for k=0..31 across 32 consecutive cycles; cpu_rst high for exactly 2 cycles before cpu_run rises.
- CPU never halts, TIMEOUT=50: timed_out=1, cycle_count=50, dump still completes, done=1.
- dump_base=1022, dump_len=4, ADDR_W=10: dump_addr sequence is 1022, 1023, 0, 1. dump_ready held low for 5 cycles: dump_valid/dump_data stable throughout.
- dump_len=0: DONE directly after halt, dump_valid never asserted. start pulsed during RUN: ignored.
- rst_n pulled low during DUMP_OUT: outputs clear asynchronously, cpu_rst=1, state IDLE; after release, a new start runs a full session correctly.
